// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: reset constants and the IF/ID pipeline register layout.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'hBFC0_0000;
  localparam int unsigned ROM_BYTES_DEFAULT = 4096;
  localparam int unsigned IF_ID_PC_W        = 32;

  typedef struct packed {
    logic [31:0]           instr;
    logic [IF_ID_PC_W-1:0] pc;
    logic [IF_ID_PC_W-1:0] pc4;
    logic                  valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: fetch drives the byte address, instrmem returns the word combinationally.
interface fetch_stage_if #(
  parameter int unsigned A_WIDTH = 32
);
  logic [A_WIDTH-1:0] addr;
  logic [31:0]        rdata;

  modport master (output addr, input rdata);
  modport slave  (input addr, output rdata);
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC selection and ROM window / alignment check on the current PC.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned        A_WIDTH   = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC  = A_WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned        ROM_BYTES = ROM_BYTES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               freeze_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [A_WIDTH-1:0] redirect_pc_i,
  output logic [A_WIDTH-1:0] pc_o,
  output logic [A_WIDTH-1:0] pc4_o,
  output logic               fault_o
);

  localparam logic [A_WIDTH-1:0] LAST_PC = RESET_PC + A_WIDTH'(ROM_BYTES) - A_WIDTH'(4);

  logic [A_WIDTH-1:0] pc_q;
  logic [A_WIDTH-1:0] pc_d;

  assign pc_o    = pc_q;
  assign pc4_o   = pc_q + A_WIDTH'(4);
  assign fault_o = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || (pc_q > LAST_PC);

  always_comb begin
    pc_d = pc_q;
    if (freeze_i)        pc_d = pc_q;
    else if (redirect_i) pc_d = redirect_pc_i;
    else if (stall_i)    pc_d = pc_q;
    else                 pc_d = pc4_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instrmem and registers the fetched word into IF/ID.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned        A_WIDTH   = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC  = A_WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned        ROM_BYTES = ROM_BYTES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 redirect_i,
  input  logic [A_WIDTH-1:0]   redirect_pc_i,
  fetch_stage_if.master        imem,
  output logic [31:0]          if_instr_o,
  output logic [A_WIDTH-1:0]   if_pc_o,
  output logic [A_WIDTH-1:0]   if_pc4_o,
  output logic                 if_valid_o,
  output logic                 fault_o
);

  logic [A_WIDTH-1:0] pc;
  logic [A_WIDTH-1:0] pc4;
  logic               fault_cond;
  logic               fault_q;
  logic               faulted;
  if_id_t             if_id_q;
  if_id_t             if_id_d;

  // Freeze on the faulting edge itself, not one edge later, so the PC sticks at the bad value.
  assign faulted = fault_q | fault_cond;

  fetch_pc_reg #(
    .A_WIDTH   (A_WIDTH),
    .RESET_PC  (RESET_PC),
    .ROM_BYTES (ROM_BYTES)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .freeze_i      (faulted),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc),
    .pc4_o         (pc4),
    .fault_o       (fault_cond)
  );

  assign imem.addr = pc;

  always_comb begin
    if_id_d = if_id_q;
    if (flush_i || redirect_i) begin
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
    end else if (stall_i) begin
      if_id_d = if_id_q;
    end else if (faulted) begin
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
    end else begin
      if_id_d.instr = imem.rdata;
      if_id_d.pc    = IF_ID_PC_W'(pc);
      if_id_d.pc4   = IF_ID_PC_W'(pc4);
      if_id_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q.instr <= NOP_INSTR;
      if_id_q.pc    <= '0;
      if_id_q.pc4   <= '0;
      if_id_q.valid <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
      fault_q <= faulted;
    end
  end

  assign if_instr_o = if_id_q.instr;
  assign if_pc_o    = A_WIDTH'(if_id_q.pc);
  assign if_pc4_o   = A_WIDTH'(if_id_q.pc4);
  assign if_valid_o = if_id_q.valid;
  assign fault_o    = fault_q;

endmodule
